lc2k_control: RTL and testbench
===============================

Name: lc2k_control

Overview:
- Multicycle LC2K sequencer: drives the datapath ALU's operand and operation inputs, and consumes its result and branch-equal flag.
- Fetches from a unified memory over a req/ready handshake, decodes LC2K instructions, owns the 8x32 register file and PC, and sequences add/nor/lw/sw/beq/jalr/halt/noop.
- Sits between the memory and the combinational ALU at the top of the CPU.

Parameters:
- ADDR_WIDTH, 16, memory word-address and PC width.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- memReq  output  1  memory request valid
- memWrite  output  1  1 = store, 0 = read; valid with memReq
- memAddr  output  ADDR_WIDTH  word address
- memWData  output  32  store data
- memRData  input  32  read data; valid in the cycle memReady=1
- memReady  input  1  completes the current request
- aluValA  output  32  ALU operand A
- aluValB  output  32  ALU operand B
- CONTROL_OPERATION  output  2  0=ADD, 1=NOR, 2=EQUAL
- aluResult  input  32  ALU combinational result
- CONTROL_BEQ  input  1  ALU equal flag; meaningful only when CONTROL_OPERATION=2
- pc  output  ADDR_WIDTH  current PC
- halted  output  1  high in HALT
- instrCount  output  32  retired-instruction counter

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=FETCH, pc=RESET_PC, all 8 registers=0, instrCount=0.
  - memReq=0, memWrite=0, halted=0, aluValA=aluValB=0, CONTROL_OPERATION=0.
  - Reset mid-transaction abandons it immediately; memReq=0 in the following cycle.
- Instruction fields:
  - opcode=[24:22], regA=[21:19], regB=[18:16], dest=[2:0].
  - offset=[15:0], sign-extended to 32 bits.
  - Branch and address arithmetic is modulo 2^ADDR_WIDTH.
- FETCH:
  - memReq=1, memWrite=0, memAddr=pc.
  - Stays in FETCH while memReady=0, with memReq held and memAddr stable.
  - memReady=1 latches memRData into the instruction register and moves to DECODE.
- DECODE:
  - Latches rA=R[regA] and rB=R[regB].
  - halt -> HALT; noop -> RETIRE; jalr -> WB; otherwise -> EXEC.
- EXEC (ALU inputs registered, stable for the whole cycle; aluResult and CONTROL_BEQ sampled at the end of the cycle):
  - add: A=rA, B=rB, op=0 -> WB.
  - nor: A=rA, B=rB, op=1 -> WB.
  - lw/sw: A=rA, B=sext(offset), op=0; latch aluResult[ADDR_WIDTH-1:0] as address -> MEM.
  - beq: A=rA, B=rB, op=2. CONTROL_BEQ=1 -> pc=pc+1+offset; else pc=pc+1. Both -> RETIRE-no-pc.
- MEM:
  - memReq=1, memAddr=latched address; memWrite=1 for sw, with memWData=rB.
  - Holds until memReady=1.
  - lw captures memRData -> WB; sw -> RETIRE.
- WB:
  - add/nor: R[dest]=ALU result.
  - lw: R[regB]=loaded data.
  - jalr: R[regB]=pc+1, zero-extended; pc=rA[ADDR_WIDTH-1:0]. If regA==regB, the jump uses the pre-write rA.
  - Writes to register 0 are performed; there is no hardwired zero.
  - -> RETIRE (jalr: pc already updated).
- RETIRE:
  - pc=pc+1 unless already updated by beq/jalr.
  - instrCount+=1, wrapping at 2^32.
  - -> FETCH.
- HALT:
  - halted=1, instrCount incremented once on entry (halt counts as retired).
  - pc is left at the halt address; memReq=0.
  - Stays in HALT until reset.
- Latency with memReady tied high: add/nor=5 cycles, lw=6, sw=5, beq=4, jalr=4, noop=3; each memory wait cycle adds 1.
- memReq is never asserted outside FETCH and MEM. No back-to-back requests: DECODE always separates a fetch from a data access.

Test Plan:
- R1=5, R2=7, "add 1 2 3", memReady=1 -> EXEC drives aluValA=5, aluValB=7, CONTROL_OPERATION=0; R3=12, pc+1, instrCount=1 after 5 cycles.
- "lw 0 4 3" with mem[3]=0xDEADBEEF and 2 wait cycles on the data access -> memAddr=3 held 3 cycles; R4=0xDEADBEEF; total 8 cycles.
- "sw 1 2 -1" with R1=10, R2=0x55 -> memWrite=1, memAddr=9, memWData=0x55; no register changes.
- beq with rA==rB and offset=-3 at pc=10 -> op=2, next fetch address 8; with rA!=rB -> 11.
- "jalr 3 3" with R3=20 at pc=4 -> R3=5, next fetch at 20.
- "halt" -> halted=1, memReq=0 stays low for 20 cycles; rst_n=0 for one cycle during a stalled lw MEM cycle -> memReq=0 next cycle, pc=RESET_PC, registers=0.

Source files
------------

// File: rtl/lc2k_control.sv
// Multicycle LC2K sequencer: fetches over a req/ready memory port, decodes, owns
// the 8x32 register file and PC, and drives a combinational ALU in the EXEC state.
module lc2k_control #(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  memReq,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWData,
  input  logic [31:0]           memRData,
  input  logic                  memReady,
  output logic [31:0]           aluValA,
  output logic [31:0]           aluValB,
  output logic [1:0]            CONTROL_OPERATION,
  input  logic [31:0]           aluResult,
  input  logic                  CONTROL_BEQ,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic [31:0]           instrCount
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StRetire, StHalt
  } state_e;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpNor  = 3'd1;
  localparam logic [2:0] OpLw   = 3'd2;
  localparam logic [2:0] OpSw   = 3'd3;
  localparam logic [2:0] OpBeq  = 3'd4;
  localparam logic [2:0] OpJalr = 3'd5;
  localparam logic [2:0] OpHalt = 3'd6;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluNor = 2'd1;
  localparam logic [1:0] AluEq  = 2'd2;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]             ir_q, ir_d;
  logic [31:0]             ra_q, ra_d;
  logic [31:0]             rb_q, rb_d;
  logic [31:0]             alu_res_q, alu_res_d;
  logic [31:0]             mdr_q, mdr_d;
  logic                    pc_done_q, pc_done_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [31:0]             alu_a_q, alu_a_d;
  logic [31:0]             alu_b_q, alu_b_d;
  logic [1:0]              alu_op_q, alu_op_d;
  logic [31:0]             regs_q [8];

  logic                    rf_we;
  logic [2:0]              rf_waddr;
  logic [31:0]             rf_wdata;

  logic [2:0]              opcode;
  logic [2:0]              reg_a;
  logic [2:0]              reg_b;
  logic [31:0]             sext_off;
  logic [ADDR_WIDTH-1:0]   off_a;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic                    unused_bits;

  assign opcode   = ir_q[24:22];
  assign reg_a    = ir_q[21:19];
  assign reg_b    = ir_q[18:16];
  assign sext_off = {{16{ir_q[15]}}, ir_q[15:0]};
  assign off_a    = sext_off[ADDR_WIDTH-1:0];
  assign pc_inc   = pc_q + ADDR_WIDTH'(1);

  // Upper instruction bits are don't-care; only the low rA bits feed the jalr target.
  assign unused_bits = ^{ir_q[31:25], ra_q};

  assign memReq            = mem_req_q;
  assign memWrite          = mem_write_q;
  assign memAddr           = mem_addr_q;
  assign memWData          = mem_wdata_q;
  assign aluValA           = alu_a_q;
  assign aluValB           = alu_b_q;
  assign CONTROL_OPERATION = alu_op_q;
  assign pc                = pc_q;
  assign halted            = (state_q == StHalt);
  assign instrCount        = cnt_q;

  // State, datapath registers and register file; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      alu_res_q   <= '0;
      mdr_q       <= '0;
      pc_done_q   <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= AluAdd;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      alu_res_q   <= alu_res_d;
      mdr_q       <= mdr_d;
      pc_done_q   <= pc_done_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Next-state logic; memory and ALU outputs are set up for the state being entered.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    alu_res_d   = alu_res_q;
    mdr_d       = mdr_q;
    pc_done_d   = pc_done_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rf_we       = 1'b0;
    rf_waddr    = ir_q[2:0];
    rf_wdata    = alu_res_q;

    case (state_q)
      StFetch: begin
        // Right after reset the request is not yet up; raise it before accepting ready.
        if (mem_req_q && memReady) begin
          ir_d      = memRData;
          mem_req_d = 1'b0;
          state_d   = StDecode;
        end else begin
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = pc_q;
        end
      end
      StDecode: begin
        ra_d      = regs_q[reg_a];
        rb_d      = regs_q[reg_b];
        pc_done_d = 1'b0;
        alu_a_d   = regs_q[reg_a];
        alu_b_d   = regs_q[reg_b];
        case (opcode)
          OpAdd: begin alu_op_d = AluAdd; state_d = StExec; end
          OpNor: begin alu_op_d = AluNor; state_d = StExec; end
          OpLw, OpSw: begin
            alu_b_d  = sext_off;
            alu_op_d = AluAdd;
            state_d  = StExec;
          end
          OpBeq: begin alu_op_d = AluEq; state_d = StExec; end
          OpJalr: state_d = StWb;
          OpHalt: begin
            cnt_d   = cnt_q + 32'd1;
            state_d = StHalt;
          end
          default: state_d = StRetire;
        endcase
      end
      StExec: begin
        alu_res_d = aluResult;
        case (opcode)
          OpLw, OpSw: begin
            mem_req_d   = 1'b1;
            mem_addr_d  = aluResult[ADDR_WIDTH-1:0];
            mem_write_d = (opcode == OpSw);
            mem_wdata_d = rb_q;
            state_d     = StMem;
          end
          OpBeq: begin
            pc_d      = CONTROL_BEQ ? (pc_inc + off_a) : pc_inc;
            pc_done_d = 1'b1;
            state_d   = StRetire;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        if (memReady) begin
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          mdr_d       = memRData;
          state_d     = (opcode == OpLw) ? StWb : StRetire;
        end
      end
      StWb: begin
        rf_we = 1'b1;
        case (opcode)
          OpLw: begin
            rf_waddr = reg_b;
            rf_wdata = mdr_q;
          end
          OpJalr: begin
            // ra_q was captured before this write, so regA==regB jumps to the old value.
            rf_waddr  = reg_b;
            rf_wdata  = 32'(pc_inc);
            pc_d      = ra_q[ADDR_WIDTH-1:0];
            pc_done_d = 1'b1;
          end
          default: begin
            rf_waddr = ir_q[2:0];
            rf_wdata = alu_res_q;
          end
        endcase
        state_d = StRetire;
      end
      StRetire: begin
        if (!pc_done_q) pc_d = pc_inc;
        cnt_d       = cnt_q + 32'd1;
        mem_req_d   = 1'b1;
        mem_write_d = 1'b0;
        mem_addr_d  = pc_d;
        state_d     = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_lc2k_control.sv
// Bench for lc2k_control: ISA-level model predicts every memory request (cycle,
// address, data), ALU operands in EXEC, and halt state; memory waits randomised.
module tb_lc2k_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memReq, memWrite, memReady;
  logic [15:0] memAddr, pc;
  logic [31:0] memWData, memRData, aluValA, aluValB, aluResult, instrCount;
  logic [1:0]  CONTROL_OPERATION;
  logic        CONTROL_BEQ, halted;

  always #5 clk = ~clk;

  lc2k_control dut (
    .clk(clk), .rst_n(rst_n), .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
    .memWData(memWData), .memRData(memRData), .memReady(memReady), .aluValA(aluValA),
    .aluValB(aluValB), .CONTROL_OPERATION(CONTROL_OPERATION), .aluResult(aluResult),
    .CONTROL_BEQ(CONTROL_BEQ), .pc(pc), .halted(halted), .instrCount(instrCount)
  );

  // Environment ALU
  always_comb begin
    case (CONTROL_OPERATION)
      2'd0:    aluResult = aluValA + aluValB;
      2'd1:    aluResult = ~(aluValA | aluValB);
      default: aluResult = 32'h0;
    endcase
  end
  assign CONTROL_BEQ = (aluValA == aluValB);

  int          n, checks, fails;
  logic [31:0] env_mem [256];
  logic [31:0] mdl_mem [256];
  logic [31:0] m_regs [8];
  logic [15:0] m_pc;
  logic [31:0] m_count;
  int          exp_kind, exp_rise;
  logic [15:0] exp_addr;
  logic        exp_wr;
  logic [31:0] exp_wdata;
  bit          pending, after_hs, alu_en, halt_en, done, rnd_waits;
  int          wcnt, pend_kind, pend_age, alu_cyc, halt_cyc, halt_left, force_dw, addr3_cnt;
  logic [15:0] pend_addr;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [2:0]  cur_op;
  int          cur_lat;
  bit          cur_mem, cur_alu;
  logic [15:0] cur_daddr;
  logic        cur_dwr;
  logic [31:0] cur_dwdata;
  int          fetch_rise[$];
  int          fetch_addr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  function automatic logic [31:0] enc(input int op, input int a, input int b, input int off);
    return {7'b0, op[2:0], a[2:0], b[2:0], off[15:0]};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    env_mem[addr] = w;
    mdl_mem[addr] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) put(i, 32'h0);
  endtask

  // ISA-level execution of the instruction at m_pc
  task automatic exec_model();
    logic [31:0] ins, a, b, s;
    logic [15:0] tgt;
    ins = mdl_mem[m_pc[7:0]];
    cur_op = ins[24:22];
    a = m_regs[ins[21:19]];
    b = m_regs[ins[18:16]];
    s = {{16{ins[15]}}, ins[15:0]};
    cur_mem = 0;
    cur_alu = 0;
    cur_lat = 0;
    case (cur_op)
      3'd0, 3'd1: begin
        m_regs[ins[2:0]] = (cur_op == 3'd0) ? a + b : ~(a | b);
        alu_a = a; alu_b = b; alu_op = cur_op[1:0]; cur_alu = 1;
        m_pc = m_pc + 16'd1; cur_lat = 5;
      end
      3'd2, 3'd3: begin
        cur_daddr = a[15:0] + s[15:0];
        alu_a = a; alu_b = s; alu_op = 2'd0; cur_alu = 1; cur_mem = 1;
        cur_dwr = (cur_op == 3'd3);
        cur_dwdata = b;
        if (cur_op == 3'd2) m_regs[ins[18:16]] = mdl_mem[cur_daddr[7:0]];
        else mdl_mem[cur_daddr[7:0]] = b;
        m_pc = m_pc + 16'd1;
      end
      3'd4: begin
        alu_a = a; alu_b = b; alu_op = 2'd2; cur_alu = 1;
        m_pc = m_pc + 16'd1 + ((a == b) ? s[15:0] : 16'd0); cur_lat = 4;
      end
      3'd5: begin
        tgt = a[15:0];
        m_regs[ins[18:16]] = {16'h0, m_pc + 16'd1};
        m_pc = tgt; cur_lat = 4;
      end
      3'd6: ;
      default: begin m_pc = m_pc + 16'd1; cur_lat = 3; end
    endcase
    m_count++;
  endtask

  // Per-cycle compare and memory responder
  task automatic step();
    if (after_hs) begin
      chk("req_drop_after_handshake", memReq, 0);
      after_hs = 0;
    end
    if (memReq && memAddr == 16'd3) addr3_cnt++;
    if (pending) begin
      chk("req_held", memReq, 1);
      chk("addr_held", memAddr, pend_addr);
    end else if (memReq) begin
      pend_kind = exp_kind;
      if (exp_kind == 0) begin
        chk("unexpected_req", memReq, 0);
      end else begin
        chk("req_cycle", n, exp_rise);
        chk("req_addr", memAddr, exp_addr);
        chk("req_write", memWrite, exp_wr);
        if (exp_wr) chk("req_wdata", memWData, exp_wdata);
        if (exp_kind == 1) begin
          chk("pc_at_fetch", pc, m_pc);
          chk("count_at_fetch", instrCount, m_count);
          fetch_rise.push_back(n);
          fetch_addr.push_back(int'(memAddr));
          exec_model();
        end
      end
      exp_kind = 0;
      pending = 1;
      pend_addr = memAddr;
      pend_age = 0;
      if (pend_kind == 2 && force_dw >= 0) wcnt = force_dw;
      else wcnt = rnd_waits ? int'($urandom_range(0, 2)) : 0;
    end else if (exp_kind != 0 && n > exp_rise) begin
      chk("req_timeout", n, exp_rise);
      exp_kind = 0;
      done = 1;
    end
    if (alu_en && n == alu_cyc) begin
      chk("alu_a", aluValA, alu_a);
      chk("alu_b", aluValB, alu_b);
      chk("alu_op", CONTROL_OPERATION, alu_op);
      alu_en = 0;
    end
    if (halt_en && n >= halt_cyc) begin
      chk("halted", halted, 1);
      chk("halt_req_low", memReq, 0);
      chk("halt_pc", pc, m_pc);
      chk("halt_count", instrCount, m_count);
      halt_left--;
      if (halt_left == 0) begin halt_en = 0; done = 1; end
    end else if (!halt_en) begin
      chk("not_halted", halted, 0);
    end
    memReady = 0;
    if (pending) begin
      if (wcnt == 0) begin
        memReady = 1;
        memRData = env_mem[memAddr[7:0]];
        if (memWrite) env_mem[memAddr[7:0]] = memWData;
        pending = 0;
        after_hs = 1;
        if (pend_kind == 1) begin
          if (cur_alu) begin alu_en = 1; alu_cyc = n + 2; end
          if (cur_op == 3'd6) begin
            halt_en = 1; halt_cyc = n + 2; halt_left = 20;
          end else if (cur_mem) begin
            exp_kind = 2; exp_rise = n + 3; exp_addr = cur_daddr;
            exp_wr = cur_dwr; exp_wdata = cur_dwdata;
          end else begin
            exp_kind = 1; exp_rise = n + cur_lat; exp_addr = m_pc; exp_wr = 0;
          end
        end else if (pend_kind == 2) begin
          exp_kind = 1; exp_rise = n + ((cur_op == 3'd2) ? 3 : 2);
          exp_addr = m_pc; exp_wr = 0;
        end
      end else begin
        wcnt--;
        pend_age++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    memReady = 0;
    tick();
    chk("rst_memReq", memReq, 0);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instrCount, 0);
    chk("rst_aluA", aluValA, 0);
    chk("rst_aluB", aluValB, 0);
    chk("rst_op", CONTROL_OPERATION, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_pc = 0; m_count = 0;
    pending = 0; after_hs = 0; alu_en = 0; halt_en = 0; done = 0;
    exp_kind = 1; exp_rise = n + 1; exp_addr = 0; exp_wr = 0;
    addr3_cnt = 0;
    fetch_rise.delete();
    fetch_addr.delete();
  endtask

  task automatic run_prog(input int limit, input int budget);
    int start;
    start = n;
    while (!done && m_count < limit) begin
      if (n - start > budget) begin
        chk("cycle_budget", n - start, budget);
        break;
      end
      tick();
      step();
    end
  endtask

  initial begin
    n = 0; checks = 0; fails = 0;
    rst_n = 0; memReady = 0; memRData = 0;
    rnd_waits = 0; force_dw = -1;

    // add with operands loaded from memory
    clear_mem();
    put(20, 32'd5); put(21, 32'd7);
    put(0, enc(2, 0, 1, 20)); put(1, enc(2, 0, 2, 21));
    put(2, enc(0, 1, 2, 3)); put(3, enc(3, 0, 3, 22)); put(4, enc(6, 0, 0, 0));
    do_reset();
    run_prog(1000, 500);
    chk("p1_model_r1", m_regs[1], 32'd5);
    chk("p1_model_r3", m_regs[3], 32'd12);
    chk("p1_store", env_mem[22], 32'd12);
    chk("p1_count", instrCount, 32'd5);
    chk("p1_add_latency", fetch_rise[3] - fetch_rise[2], 5);

    // lw with two data wait cycles
    clear_mem();
    force_dw = 2;
    put(0, enc(2, 0, 4, 3)); put(1, enc(3, 0, 4, 30)); put(2, enc(6, 0, 0, 0));
    put(3, 32'hDEADBEEF);
    do_reset();
    run_prog(1000, 500);
    force_dw = -1;
    chk("p2_store", env_mem[30], 32'hDEADBEEF);
    chk("p2_addr_hold", addr3_cnt, 3);
    chk("p2_lw_latency", fetch_rise[1] - fetch_rise[0], 8);

    // sw with negative offset
    clear_mem();
    put(40, 32'd10); put(41, 32'h55);
    put(0, enc(2, 0, 1, 40)); put(1, enc(2, 0, 2, 41));
    put(2, enc(3, 1, 2, -1)); put(3, enc(6, 0, 0, 0));
    do_reset();
    run_prog(1000, 500);
    chk("p3_store", env_mem[9], 32'h55);
    chk("p3_sw_latency", fetch_rise[3] - fetch_rise[2], 5);

    // beq taken backwards then not taken
    clear_mem();
    put(41, 32'h55);
    put(0, enc(2, 0, 1, 41)); put(1, enc(4, 0, 0, 8)); put(10, enc(4, 0, 0, -3));
    put(8, enc(4, 0, 1, 5)); put(9, enc(6, 0, 0, 0));
    do_reset();
    run_prog(1000, 500);
    chk("p4_fetch2", fetch_addr[2], 10);
    chk("p4_fetch3", fetch_addr[3], 8);
    chk("p4_fetch4", fetch_addr[4], 9);
    chk("p4_pc", pc, 16'd9);
    chk("p4_count", instrCount, 32'd5);
    chk("p4_beq_latency", fetch_rise[2] - fetch_rise[1], 4);

    // jalr with regA==regB
    clear_mem();
    put(40, 32'd20);
    put(0, enc(2, 0, 3, 40)); put(1, enc(7, 0, 0, 0)); put(2, enc(7, 0, 0, 0));
    put(3, enc(7, 0, 0, 0)); put(4, enc(5, 3, 3, 0));
    put(20, enc(3, 0, 3, 41)); put(21, enc(6, 0, 0, 0));
    do_reset();
    run_prog(1000, 500);
    chk("p5_link", env_mem[41], 32'd5);
    chk("p5_target", fetch_addr[5], 20);
    chk("p5_pc", pc, 16'd21);
    chk("p5_jalr_latency", fetch_rise[5] - fetch_rise[4], 4);
    chk("p5_noop_latency", fetch_rise[2] - fetch_rise[1], 3);

    // reset during a stalled lw data access
    clear_mem();
    force_dw = 1000;
    put(0, enc(1, 0, 0, 1)); put(1, enc(2, 0, 2, 41));
    do_reset();
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        tick();
        step();
        if (pending && pend_kind == 2 && pend_age >= 2) break;
      end
      chk("p6_reached_stall", (k < 200) ? 1 : 0, 1);
    end
    force_dw = -1;
    put(50, 32'hAAAA);
    put(0, enc(3, 0, 1, 50)); put(1, enc(6, 0, 0, 0));
    do_reset();
    run_prog(1000, 500);
    chk("p6_r1_cleared", env_mem[50], 32'h0);

    // randomized programs with random memory waits
    rnd_waits = 1;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        int r;
        logic [31:0] w;
        r = int'($urandom_range(0, 99));
        w = $urandom;
        if (r < 20) w[24:22] = 3'd0;
        else if (r < 35) w[24:22] = 3'd1;
        else if (r < 55) w[24:22] = 3'd2;
        else if (r < 70) w[24:22] = 3'd3;
        else if (r < 82) w[24:22] = 3'd4;
        else if (r < 87) w[24:22] = 3'd5;
        else if (r < 89) w[24:22] = 3'd6;
        else w[24:22] = 3'd7;
        if (w[24:22] == 3'd4) w[15:0] = 16'($urandom_range(0, 15)) - 16'd8;
        put(i, w);
      end
      do_reset();
      run_prog(200, 6000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
